// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline hazard sequencer.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    localparam int REG_AW = 5;

    // addi x0, x0, 0 -- the canonical RV32 NOP loaded by flush/bubble controls
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mdu_wait_timer.sv
// Clear/enable cycle counter for the MDU wait window; tc flags the last allowed cycle.
module mdu_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TERM);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / MDU-freeze / branch-flush sequencer for the 5-stage RV32 pipe.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int REG_AW      = pipeline_ctrl_pkg::REG_AW,
    parameter int MDU_TIMEOUT = 64
`ifdef HAZARD_PERF_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_mdu_op,
    input  logic              ex_branch_taken,
    input  logic              mdu_done,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              stall_idex,
    output logic              bubble_idex,
    output logic              bubble_exmem,
    output logic              mdu_start,
    output logic              mdu_timeout_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

    import pipeline_ctrl_pkg::*;

    state_t state;
    logic   run_mdu;
    logic   run_branch;
    logic   load_use;
    logic   timer_tc;

    assign run_mdu    = (state == RUN) && ex_valid && ex_mdu_op;
    assign run_branch = ex_valid && ex_branch_taken;

    // x0 is hardwired zero, so a load targeting it can never feed a consumer
    assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    mdu_wait_timer #(
        .TIMEOUT (MDU_TIMEOUT)
    ) u_mdu_wait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_mdu),
        .en    (state == MDU_WAIT),
        .tc    (timer_tc)
    );

    always_comb begin
        stall_pc     = 1'b0;
        stall_ifid   = 1'b0;
        flush_ifid   = 1'b0;
        stall_idex   = 1'b0;
        bubble_idex  = 1'b0;
        bubble_exmem = 1'b0;
        mdu_start    = 1'b0;
        if (rst_n) begin
            if (state == RUN) begin
                if (run_mdu) begin
                    mdu_start    = 1'b1;
                    stall_pc     = 1'b1;
                    stall_ifid   = 1'b1;
                    stall_idex   = 1'b1;
                    bubble_exmem = 1'b1;
                end else if (run_branch) begin
                    // the ID instruction is wrong-path, so its load-use match is moot
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end else if (load_use) begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
            end else if (!mdu_done) begin
                stall_pc     = 1'b1;
                stall_ifid   = 1'b1;
                stall_idex   = 1'b1;
                bubble_exmem = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            mdu_timeout_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (run_mdu) state <= MDU_WAIT;
                end
                MDU_WAIT: begin
                    if (mdu_done) begin
                        state <= RUN;
                    end else if (timer_tc) begin
                        mdu_timeout_err <= 1'b1;
                        state           <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_pc)   perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (flush_ifid) perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`endif

    // An EX instruction cannot be both an MDU op and a taken branch
    always @(posedge clk) begin
        if (rst_n) assert (!(ex_valid && ex_mdu_op && ex_branch_taken));
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic.
module tb_pipeline_hazard_ctrl;

    localparam int REG_AW      = 5;
    localparam int MDU_TIMEOUT = 8;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [31:0] pstall;
        logic [31:0] pflush;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic [REG_AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic ex_valid = 1'b0, ex_mem_read = 1'b0, ex_mdu_op = 1'b0;
    logic ex_branch_taken = 1'b0, mdu_done = 1'b0;
    logic stall_pc, stall_ifid, flush_ifid, stall_idex, bubble_idex, bubble_exmem;
    logic mdu_start, mdu_timeout_err;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    // staged stimulus, applied by step()
    logic s_rst_n, s_id_valid, s_use1, s_use2, s_ex_valid, s_mem_read, s_mdu, s_br, s_done;
    logic [REG_AW-1:0] s_rs1, s_rs2, s_rd;

    // reference model state
    bit m_busy;
    int m_waited;
    bit m_err;
    int unsigned m_pstall, m_pflush;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_AW      (REG_AW),
        .MDU_TIMEOUT (MDU_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_mdu_op       (ex_mdu_op),
        .ex_branch_taken (ex_branch_taken),
        .mdu_done        (mdu_done),
        .stall_pc        (stall_pc),
        .stall_ifid      (stall_ifid),
        .flush_ifid      (flush_ifid),
        .stall_idex      (stall_idex),
        .bubble_idex     (bubble_idex),
        .bubble_exmem    (bubble_exmem),
        .mdu_start       (mdu_start),
        .mdu_timeout_err (mdu_timeout_err)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

`ifndef HAZARD_PERF_EN
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

    task automatic idle();
        s_rst_n = 1'b1; s_id_valid = 1'b0; s_use1 = 1'b0; s_use2 = 1'b0;
        s_ex_valid = 1'b0; s_mem_read = 1'b0; s_mdu = 1'b0; s_br = 1'b0; s_done = 1'b0;
        s_rs1 = '0; s_rs2 = '0; s_rd = '0;
    endtask

    // A later instruction needs a register the load in EX has not yet produced
    function automatic bit needs_load_result();
        if (!(s_ex_valid && s_mem_read && s_id_valid)) return 0;
        if (s_rd == 0) return 0;
        return (s_use1 && s_rs1 == s_rd) || (s_use2 && s_rs2 == s_rd);
    endfunction

    task automatic step();
        bit spc, sif, fl, sidex, bidex, bexm, start;
        exp_t e;
        @(negedge clk);
        #1;
        rst_n = s_rst_n; id_valid = s_id_valid; id_rs1 = s_rs1; id_rs2 = s_rs2;
        id_use_rs1 = s_use1; id_use_rs2 = s_use2; ex_valid = s_ex_valid; ex_rd = s_rd;
        ex_mem_read = s_mem_read; ex_mdu_op = s_mdu; ex_branch_taken = s_br; mdu_done = s_done;
        {spc, sif, fl, sidex, bidex, bexm, start} = '0;
        if (!s_rst_n) begin
            m_busy = 0; m_waited = 0; m_err = 0; m_pstall = 0; m_pflush = 0;
        end
        e.pstall = m_pstall;
        e.pflush = m_pflush;
        e.ctrl[0] = m_err;
        if (s_rst_n) begin
            if (!m_busy) begin
                if (s_ex_valid && s_mdu) begin
                    start = 1; spc = 1; sif = 1; sidex = 1; bexm = 1;
                    m_busy = 1; m_waited = 0;
                end else if (s_ex_valid && s_br) begin
                    fl = 1; bidex = 1;
                end else if (needs_load_result()) begin
                    spc = 1; sif = 1; bidex = 1;
                end
            end else if (s_done) begin
                m_busy = 0;
            end else begin
                spc = 1; sif = 1; sidex = 1; bexm = 1;
                m_waited++;
                if (m_waited == MDU_TIMEOUT) begin
                    m_err = 1; m_busy = 0;
                end
            end
            m_pstall += spc;
            m_pflush += fl;
        end
        e.ctrl[7:1] = {spc, sif, fl, sidex, bidex, bexm, start};
        exp_q.push_back(e);
        cyc++;
    endtask

    // Monitor: every cycle presents a full control word
    initial begin
        exp_t e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {stall_pc, stall_ifid, flush_ifid, stall_idex, bubble_idex,
                       bubble_exmem, mdu_start, mdu_timeout_err};
                n_checks++;
                if (got !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL ctrl cycle %0d: got %b expected %b (pc,ifid,flush,idex,bub_idex,bub_exmem,start,err)",
                             cyc, got, e.ctrl);
                end
`ifdef HAZARD_PERF_EN
                n_checks++;
                if (perf_stall_cnt !== e.pstall || perf_flush_cnt !== e.pflush) begin
                    n_fail++;
                    $display("FAIL perf cycle %0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             cyc, perf_stall_cnt, perf_flush_cnt, e.pstall, e.pflush);
                end
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        s_rst_n = 1'b0;
        repeat (3) step();
        idle();
        step();

        // load-use on rs1: one stall cycle, then the bubble removes the match
        s_ex_valid = 1; s_mem_read = 1; s_rd = 5; s_id_valid = 1; s_rs1 = 5; s_use1 = 1; s_rs2 = 1; s_use2 = 1;
        step();
        s_ex_valid = 0; s_mem_read = 0;
        step();
        idle(); step();

        // x0 never hazards; unused rs2 never hazards
        s_ex_valid = 1; s_mem_read = 1; s_rd = 0; s_id_valid = 1; s_rs1 = 0; s_use1 = 1;
        step();
        s_rd = 7; s_rs2 = 7; s_use2 = 0; s_rs1 = 3; s_use1 = 1;
        step();

        // taken branch beats a simultaneous load-use match
        s_br = 1; s_rs1 = 7; s_use1 = 1;
        step();
        idle(); step();

        // MUL completing after five wait cycles
        s_ex_valid = 1; s_mdu = 1;
        step();
        s_mdu = 0;
        repeat (5) step();
        s_done = 1; step();
        idle(); repeat (2) step();

        // MDU never completes: timeout, sticky error
        s_ex_valid = 1; s_mdu = 1;
        step();
        s_mdu = 0; s_ex_valid = 0;
        repeat (MDU_TIMEOUT + 3) step();
        s_done = 1; step();
        idle(); step();

        // reset while waiting: immediate zero outputs, no reissued start
        s_ex_valid = 1; s_mdu = 1;
        step();
        s_mdu = 0; s_ex_valid = 0;
        repeat (2) step();
        s_rst_n = 0; step();
        idle(); repeat (2) step();

        // randomized traffic over a tiny register space to provoke matches
        for (int i = 0; i < 2000; i++) begin
            s_rst_n    = ($urandom_range(0, 99) != 0);
            s_id_valid = $urandom_range(0, 3) != 0;
            s_rs1      = REG_AW'($urandom_range(0, 3));
            s_rs2      = REG_AW'($urandom_range(0, 3));
            s_use1     = $urandom_range(0, 1);
            s_use2     = $urandom_range(0, 1);
            s_ex_valid = $urandom_range(0, 3) != 0;
            s_rd       = REG_AW'($urandom_range(0, 3));
            s_mem_read = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0:       begin s_mdu = 1; s_br = 0; end
                1, 2:    begin s_mdu = 0; s_br = 1; end
                default: begin s_mdu = 0; s_br = 0; end
            endcase
            s_done = ($urandom_range(0, 4) == 0);
            step();
        end

        idle();
        step();
        @(negedge clk);
        #3;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
